wavetable_nco_gen2: RTL and testbench
=====================================

Name: wavetable_nco_gen2

Overview:
- Parametrised, fully synchronous successor to the wavetable NCO. It generates the wave-RAM address (wave index, sample index) for one oscillator voice.
- Phase-accumulator overflow is detected from the adder carry inside the single clock domain. No derived or MSB-edge clocking.
- Adds hard-sync, a sample-advance strobe, a wrap pulse and a pending-wave status.
- Sits between the control-bus input latch and the wavetable RAM read port.

Parameters:
- ACC_WIDTH, 18, phase accumulator and tuning word width.
- OCT_WIDTH, 3, upper-octave select field width.
- SAMPLE_ADDR_WIDTH, 7, sample index width (128 samples per wave).
- WAVE_ADDR_WIDTH, 6, wave index width (64 waves per table).

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_input_latch_write_enable  in  1  captures i_input on this rising edge.
- i_input  in  ACC_WIDTH+OCT_WIDTH+WAVE_ADDR_WIDTH  packed control word, fields {wave, octave, tuning}, tuning in the LSBs.
- i_sync  in  1  hard-sync pulse; restarts the wave cycle.
- o_waveram_address  out  WAVE_ADDR_WIDTH+SAMPLE_ADDR_WIDTH  {wave index, sample index}.
- o_sample_strobe  out  1  one-cycle pulse; the sample index changed this cycle.
- o_wrap  out  1  one-cycle pulse; the sample index wrapped or sync occurred.
- o_wave_pending  out  1  latched wave field differs from the active wave index.

Behaviour:
- Reset (i_reset_n low, asynchronous): input latch, accumulator, sample index, wave index, o_sample_strobe and o_wrap all go to 0. Output address reads 0 immediately.
- Latch: a write at edge t is visible to the datapath from edge t+1. Fields: tuning = [ACC_WIDTH-1:0], octave = next OCT_WIDTH bits, wave = top WAVE_ADDR_WIDTH bits.
- Accumulator: acc <= (acc + tuning) mod 2^ACC_WIDTH every cycle. carry = carry-out of that add. Tuning 0 freezes the phase.
- Step size = 1 << octave. If octave >= SAMPLE_ADDR_WIDTH, step saturates to 1 << (SAMPLE_ADDR_WIDTH-1).
- On carry, on the same edge as the accumulator update:
  - sample <= (sample + step) mod 2^SAMPLE_ADDR_WIDTH.
  - o_sample_strobe = 1 for that cycle.
- Wrap: carry-out of the sample add. On wrap, wave index <= latched wave field and o_wrap = 1. Wave index changes only at a wrap, a sync, or reset.
- Sync (i_sync=1): acc <= 0, sample <= 0, wave index <= latched wave field, o_wrap = 1, o_sample_strobe = 0.
  - Sync has priority over carry in the same cycle.
  - A latch write in the same cycle as sync is not used by that sync; the sync uses the previous latch.
- o_wave_pending: combinational compare of the latched wave field against the active wave index.
- Latency: an address change appears on o_waveram_address in the cycle after the edge that computed the carry (registered output).

Decomposition:
- Shared package nco_pkg holds:
  - default widths as localparams;
  - field-offset constants TUNING_LSB, OCT_LSB, WAVE_LSB;
  - function octave_step(oct) that returns the saturated step.
- One natural sub-module: nco_phase_acc, containing the accumulator plus carry output. It is reused by future multi-voice variants.
- Latch, sample/wave control and output logic stay in the top module.

Test Plan:
1. Reset, write tuning=0x10000, octave=0, wave=0 -> carry every 4 cycles; sample index steps 0,1,2,... with o_sample_strobe every 4th cycle.
2. Tuning=0x20000, octave=3 -> step 8 every 2 cycles; after 16 strobes the sample index wraps to 0 with o_wrap=1 on that cycle.
3. At sample index 40, write wave=5 -> o_wave_pending=1 and the address keeps wave 0 until wrap. At wrap the address becomes {5,0} and o_wave_pending returns to 0.
4. At sample index 77, pulse i_sync in the same cycle as a carry -> next address {wave,0}, accumulator 0, o_wrap=1, no strobe.
5. Octave=7, tuning=0x3FFFF -> step saturates to 64; sample index alternates 0 and 64 on almost every cycle, wrapping on every second strobe.
6. Drive i_reset_n low mid-cycle at sample 93 -> all outputs 0 before the next clock edge. After release, nothing advances until a latch write with nonzero tuning.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared widths, control-word field offsets and octave-to-step helper for the
// wavetable NCO family.
package nco_pkg;

  localparam int ACC_WIDTH_DEF         = 18;
  localparam int OCT_WIDTH_DEF         = 3;
  localparam int SAMPLE_ADDR_WIDTH_DEF = 7;
  localparam int WAVE_ADDR_WIDTH_DEF   = 6;

  // Field offsets in the packed control word {wave, octave, tuning} at default widths.
  localparam int TUNING_LSB = 0;
  localparam int OCT_LSB    = TUNING_LSB + ACC_WIDTH_DEF;
  localparam int WAVE_LSB   = OCT_LSB + OCT_WIDTH_DEF;

  // Octaves at or beyond the sample width would step past a whole wave, so clamp to half a wave.
  function automatic logic [31:0] octave_step(input logic [31:0] oct, input int unsigned sample_w);
    logic [31:0] shamt;
    if (oct >= sample_w) begin
      shamt = sample_w - 32'd1;
    end else begin
      shamt = oct;
    end
    return 32'd1 << shamt;
  endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// Single-voice phase accumulator; exposes the adder carry-out as the phase-wrap event.
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_clear,
  input  logic [ACC_WIDTH-1:0] i_tuning,
  output logic                 o_carry
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH:0]   sum_s;

  assign sum_s   = {1'b0, acc_q} + {1'b0, i_tuning};
  assign o_carry = sum_s[ACC_WIDTH];

  // Next phase: cleared by hard-sync, otherwise the modular sum.
  always_comb begin
    acc_d = acc_q;
    if (i_clear) begin
      acc_d = '0;
    end else begin
      acc_d = sum_s[ACC_WIDTH-1:0];
    end
  end

  // Phase register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/wavetable_nco_gen2.sv
// Wavetable NCO voice: control-word latch, phase accumulator, sample/wave index
// tracking with hard-sync, and registered wave-RAM address generation.
module wavetable_nco_gen2
  import nco_pkg::*;
#(
  parameter int ACC_WIDTH         = ACC_WIDTH_DEF,
  parameter int OCT_WIDTH         = OCT_WIDTH_DEF,
  parameter int SAMPLE_ADDR_WIDTH = SAMPLE_ADDR_WIDTH_DEF,
  parameter int WAVE_ADDR_WIDTH   = WAVE_ADDR_WIDTH_DEF
) (
  input  logic                                         i_clock,
  input  logic                                         i_reset_n,
  input  logic                                         i_input_latch_write_enable,
  input  logic [ACC_WIDTH+OCT_WIDTH+WAVE_ADDR_WIDTH-1:0] i_input,
  input  logic                                         i_sync,
  output logic [WAVE_ADDR_WIDTH+SAMPLE_ADDR_WIDTH-1:0] o_waveram_address,
  output logic                                         o_sample_strobe,
  output logic                                         o_wrap,
  output logic                                         o_wave_pending
);

  localparam int IN_WIDTH = ACC_WIDTH + OCT_WIDTH + WAVE_ADDR_WIDTH;
  // Package offsets are for default widths; shift them by any width override.
  localparam int OCT_LSB_P  = OCT_LSB + (ACC_WIDTH - ACC_WIDTH_DEF);
  localparam int WAVE_LSB_P = WAVE_LSB + (ACC_WIDTH - ACC_WIDTH_DEF) + (OCT_WIDTH - OCT_WIDTH_DEF);

  logic [IN_WIDTH-1:0]          latch_q;
  logic [IN_WIDTH-1:0]          latch_d;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_q;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_d;
  logic [WAVE_ADDR_WIDTH-1:0]   wave_q;
  logic [WAVE_ADDR_WIDTH-1:0]   wave_d;
  logic                         strobe_q;
  logic                         strobe_d;
  logic                         wrap_q;
  logic                         wrap_d;

  logic [ACC_WIDTH-1:0]         tuning_s;
  logic [OCT_WIDTH-1:0]         oct_s;
  logic [WAVE_ADDR_WIDTH-1:0]   wave_field_s;
  logic [SAMPLE_ADDR_WIDTH-1:0] step_s;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_sum_s;
  logic                         sample_wrap_s;
  logic                         carry_s;

  assign tuning_s     = latch_q[OCT_LSB_P-1:TUNING_LSB];
  assign oct_s        = latch_q[WAVE_LSB_P-1:OCT_LSB_P];
  assign wave_field_s = latch_q[IN_WIDTH-1:WAVE_LSB_P];
  assign step_s       = SAMPLE_ADDR_WIDTH'(octave_step(32'(oct_s), SAMPLE_ADDR_WIDTH));

  assign {sample_wrap_s, sample_sum_s} = {1'b0, sample_q} + {1'b0, step_s};

  nco_phase_acc #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_phase_acc (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_clear  (i_sync),
    .i_tuning (tuning_s),
    .o_carry  (carry_s)
  );

  // Control-word latch; the datapath only ever sees the registered copy.
  always_comb begin
    latch_d = latch_q;
    if (i_input_latch_write_enable) begin
      latch_d = i_input;
    end else begin
      latch_d = latch_q;
    end
  end

  // Sample/wave index update: sync beats carry; a new wave is adopted only at a wrap or sync.
  always_comb begin
    sample_d = sample_q;
    wave_d   = wave_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    if (i_sync) begin
      sample_d = '0;
      wave_d   = wave_field_s;
      wrap_d   = 1'b1;
    end else if (carry_s) begin
      sample_d = sample_sum_s;
      strobe_d = 1'b1;
      if (sample_wrap_s) begin
        wave_d = wave_field_s;
        wrap_d = 1'b1;
      end else begin
        wave_d = wave_q;
        wrap_d = 1'b0;
      end
    end else begin
      sample_d = sample_q;
      wave_d   = wave_q;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      latch_q  <= '0;
      sample_q <= '0;
      wave_q   <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      latch_q  <= latch_d;
      sample_q <= sample_d;
      wave_q   <= wave_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o_waveram_address = {wave_q, sample_q};
  assign o_sample_strobe   = strobe_q;
  assign o_wrap            = wrap_q;
  assign o_wave_pending    = (wave_field_s != wave_q);

endmodule

// File: tb/tb_wavetable_nco_gen2.sv
// Directed bench for wavetable_nco_gen2 at default widths.
module tb_wavetable_nco_gen2;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [26:0] din;
  logic        sync;
  logic [12:0] addr;
  logic        strobe;
  logic        wrap;
  logic        pending;

  int vectors;
  int errors;

  wavetable_nco_gen2 dut (
    .i_clock                   (clk),
    .i_reset_n                 (rst_n),
    .i_input_latch_write_enable(we),
    .i_input                   (din),
    .i_sync                    (sync),
    .o_waveram_address         (addr),
    .o_sample_strobe           (strobe),
    .o_wrap                    (wrap),
    .o_wave_pending            (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [26:0] pack(input logic [5:0] w, input logic [2:0] o, input logic [17:0] t);
    return {w, o, t};
  endfunction

  function automatic logic [12:0] mk_addr(input logic [5:0] w, input logic [6:0] s);
    return {w, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [12:0] ea, input logic es, input logic ew);
    chk({tag, "_addr"}, 32'(addr), 32'(ea));
    chk({tag, "_strobe"}, 32'(strobe), 32'(es));
    chk({tag, "_wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    we      = 1'b0;
    din     = 27'd0;
    sync    = 1'b0;
    rst_n   = 1'b0;
    #2;
    chk_state("reset", 13'd0, 1'b0, 1'b0);
    chk("reset_pending", 32'(pending), 32'd0);
    #1;
    rst_n = 1'b1;

    // 1: tuning 0x10000, octave 0 -> strobe every 4th cycle, step 1
    din = pack(6'd0, 3'd0, 18'h10000);
    we  = 1'b1;
    tick();
    we  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      repeat (3) begin
        tick();
        chk("t1_idle_strobe", 32'(strobe), 32'd0);
      end
      tick();
      chk_state("t1_step", mk_addr(6'd0, 7'(k)), 1'b1, 1'b0);
    end

    // 2: realign mid-phase with sync, then octave 3 -> step 8 every 2 cycles
    tick();
    chk("t2_pre_strobe", 32'(strobe), 32'd0);
    din  = pack(6'd0, 3'd3, 18'h20000);
    we   = 1'b1;
    sync = 1'b1;
    tick();
    we   = 1'b0;
    sync = 1'b0;
    chk_state("t2_sync", mk_addr(6'd0, 7'd0), 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_state("t2_idle", mk_addr(6'd0, 7'((8 * k) - 8)), 1'b0, 1'b0);
      tick();
      chk_state("t2_step", mk_addr(6'd0, 7'(8 * k)), 1'b1, (k == 16));
    end

    // 3: new wave written at sample 40 is held pending until the wrap
    repeat (10) tick();
    chk("t3_at40", 32'(addr), 32'(mk_addr(6'd0, 7'd40)));
    din = pack(6'd5, 3'd3, 18'h20000);
    we  = 1'b1;
    tick();
    we  = 1'b0;
    chk("t3_pending_set", 32'(pending), 32'd1);
    chk("t3_addr_hold", 32'(addr), 32'(mk_addr(6'd0, 7'd40)));
    for (int k = 6; k <= 16; k++) begin
      tick();
      chk_state("t3_step", mk_addr((k == 16) ? 6'd5 : 6'd0, 7'(8 * k)), 1'b1, (k == 16));
      chk("t3_pending", 32'(pending), (k == 16) ? 32'd0 : 32'd1);
      tick();
      chk("t3_idle_strobe", 32'(strobe), 32'd0);
    end

    // 4: step 1 up to sample 77, then sync coincident with a carry
    din  = pack(6'd5, 3'd0, 18'h20000);
    we   = 1'b1;
    sync = 1'b1;
    tick();
    we   = 1'b0;
    sync = 1'b0;
    chk_state("t4_sync0", mk_addr(6'd5, 7'd0), 1'b0, 1'b1);
    for (int k = 1; k <= 77; k++) begin
      tick();
      tick();
      chk_state("t4_step", mk_addr(6'd5, 7'(k)), 1'b1, 1'b0);
    end
    tick();
    chk("t4_pre_strobe", 32'(strobe), 32'd0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk_state("t4_sync_carry", mk_addr(6'd5, 7'd0), 1'b0, 1'b1);
    tick();
    chk_state("t4_after_idle", mk_addr(6'd5, 7'd0), 1'b0, 1'b0);
    tick();
    chk_state("t4_after_step", mk_addr(6'd5, 7'd1), 1'b1, 1'b0);

    // 5: octave 7 saturates to step 64, carry nearly every cycle
    din  = pack(6'd5, 3'd7, 18'h3FFFF);
    we   = 1'b1;
    sync = 1'b1;
    tick();
    we   = 1'b0;
    sync = 1'b0;
    chk_state("t5_sync", mk_addr(6'd5, 7'd0), 1'b0, 1'b1);
    tick();
    chk_state("t5_first", mk_addr(6'd5, 7'd0), 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_state("t5_step", mk_addr(6'd5, (k % 2 == 1) ? 7'd64 : 7'd0), 1'b1, (k % 2 == 0));
    end

    // 6: async reset mid-cycle at sample 93
    din  = pack(6'd5, 3'd0, 18'h3FFFF);
    we   = 1'b1;
    sync = 1'b1;
    tick();
    we   = 1'b0;
    sync = 1'b0;
    tick();
    for (int k = 1; k <= 93; k++) begin
      tick();
    end
    chk_state("t6_at93", mk_addr(6'd5, 7'd93), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("t6_async_reset", 13'd0, 1'b0, 1'b0);
    chk("t6_reset_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk_state("t6_frozen", 13'd0, 1'b0, 1'b0);
    end
    din = pack(6'd0, 3'd0, 18'h10000);
    we  = 1'b1;
    tick();
    we  = 1'b0;
    repeat (3) begin
      tick();
      chk_state("t6_restart_idle", 13'd0, 1'b0, 1'b0);
    end
    tick();
    chk_state("t6_restart_step", mk_addr(6'd0, 7'd1), 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
